// File: rtl/universal_shift_register_if.sv
// Control/data bundle for the universal shift register.
// The master side drives load/shift/burst requests; the slave side is the register itself.
interface universal_shift_register_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             load;
    logic [WIDTH-1:0] d;
    logic             shift_en;
    logic [1:0]       mode;
    logic             serial_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output load, d, shift_en, mode, serial_in, start, count,
        input  q, serial_out, busy, done
    );

    modport slave (
        input  load, d, shift_en, mode, serial_in, start, count,
        output q, serial_out, busy, done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Parametrised shift register: parallel load, single-step shifts in four modes
// (lsl, lsr, rol, ror) and a counted burst sequencer that shifts one position per
// cycle and reports busy/done. All outputs are registered.
module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    universal_shift_register_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic             serial_out_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [1:0]       mode_latched_reg;
    logic [CNT_W-1:0] remaining_reg;

    // Mode of the step that would happen this cycle: live mode when idle,
    // the mode captured at burst start while bursting.
    logic [1:0]       step_mode;
    logic             step_is_rotate;
    logic             step_is_right;
    logic [WIDTH-1:0] left_next;
    logic [WIDTH-1:0] right_next;
    logic [WIDTH-1:0] q_next;
    logic             serial_out_next;

    assign step_mode      = (state_reg == BURST) ? mode_latched_reg : bus.mode;
    assign step_is_rotate = step_mode[1];
    assign step_is_right  = step_mode[0];

    // Interior bits of the left/right shifted vectors are plain neighbour moves.
    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_left
            assign left_next[gi] = q_reg[gi-1];
        end
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_right
            assign right_next[gi] = q_reg[gi+1];
        end
    endgenerate

    // End bits take either the wrapped-around bit (rotate) or the serial fill bit.
    assign left_next[0]        = step_is_rotate ? q_reg[WIDTH-1] : bus.serial_in;
    assign right_next[WIDTH-1] = step_is_rotate ? q_reg[0]       : bus.serial_in;

    assign q_next          = step_is_right ? right_next : left_next;
    assign serial_out_next = step_is_right ? q_reg[0]   : q_reg[WIDTH-1];

    // Register, output flags and burst sequencer; load overrides any shift or burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            q_reg            <= '0;
            serial_out_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            mode_latched_reg <= 2'b00;
            remaining_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            if (bus.load) begin
                // Parallel load; also aborts a burst silently (no done pulse).
                q_reg         <= bus.d;
                busy_reg      <= 1'b0;
                remaining_reg <= '0;
                state_reg     <= IDLE;
            end else if (state_reg == IDLE) begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        mode_latched_reg <= bus.mode;
                        remaining_reg    <= bus.count;
                        busy_reg         <= 1'b1;
                        state_reg        <= BURST;
                    end else begin
                        // Zero-length burst completes immediately.
                        done_reg <= 1'b1;
                    end
                end else if (bus.shift_en) begin
                    q_reg          <= q_next;
                    serial_out_reg <= serial_out_next;
                end
            end else begin
                q_reg          <= q_next;
                serial_out_reg <= serial_out_next;
                remaining_reg  <= remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
            end
        end
    end

    assign bus.q          = q_reg;
    assign bus.serial_out = serial_out_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
endmodule

// File: tb/tb_universal_shift_register.sv
// Cycle-by-cycle vector bench for the universal shift register at WIDTH=4.
// Each record holds one cycle of inputs and the outputs expected after that edge;
// expectations are queued when inputs are driven and popped when outputs are sampled.
module tb_universal_shift_register;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic          rst;
        logic          load;
        logic [W-1:0]  d;
        logic          shift_en;
        logic [1:0]    mode;
        logic          sin;
        logic          start;
        logic [CW-1:0] count;
        logic [W-1:0]  eq;
        logic          eso;
        logic          ebusy;
        logic          edone;
    } vec_t;

    typedef struct {
        string        tag;
        logic [W-1:0] q;
        logic         so;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    universal_shift_register_if #(.WIDTH(W)) bus ();

    universal_shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst_i, input logic load_i, input logic [W-1:0] d_i,
        input logic sh_i, input logic [1:0] mode_i, input logic sin_i,
        input logic start_i, input logic [CW-1:0] cnt_i,
        input logic [W-1:0] eq_i, input logic eso_i, input logic eb_i, input logic ed_i);
        vec_t v;
        v.rst = rst_i; v.load = load_i; v.d = d_i; v.shift_en = sh_i;
        v.mode = mode_i; v.sin = sin_i; v.start = start_i; v.count = cnt_i;
        v.eq = eq_i; v.eso = eso_i; v.ebusy = eb_i; v.edone = ed_i;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the sampled outputs.
    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".q"},          bus.q,                    e.q);
        cmp({e.tag, ".serial_out"}, {{(W-1){1'b0}}, bus.serial_out}, {{(W-1){1'b0}}, e.so});
        cmp({e.tag, ".busy"},       {{(W-1){1'b0}}, bus.busy},       {{(W-1){1'b0}}, e.busy});
        cmp({e.tag, ".done"},       {{(W-1){1'b0}}, bus.done},       {{(W-1){1'b0}}, e.done});
        $display("cyc %s: q=%b so=%b busy=%b done=%b", e.tag, bus.q, bus.serial_out, bus.busy, bus.done);
    endtask

    // Drive one cycle of inputs, queue its expectation, then sample after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        rst           = v.rst;
        bus.load      = v.load;
        bus.d         = v.d;
        bus.shift_en  = v.shift_en;
        bus.mode      = v.mode;
        bus.serial_in = v.sin;
        bus.start     = v.start;
        bus.count     = v.count;
        e.tag  = tag;
        e.q    = v.eq;
        e.so   = v.eso;
        e.busy = v.ebusy;
        e.done = v.edone;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.load = 1'b0; bus.d = '0; bus.shift_en = 1'b0; bus.mode = 2'b00;
        bus.serial_in = 1'b0; bus.start = 1'b0; bus.count = '0;

        //               rst  ld  d        sh  mode   sin start cnt     q        so  busy done
        // Reset state
        tbl.push_back(mk(1,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b0000, 0,  0,   0));
        // Single-step lsl with serial_in=0
        tbl.push_back(mk(0,   1,  4'b1101, 0,  2'b00, 0,  0,    3'd0,   4'b1101, 0,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 0,  0,    3'd0,   4'b1010, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 0,  0,    3'd0,   4'b0100, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 0,  0,    3'd0,   4'b1000, 0,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 0,  0,    3'd0,   4'b0000, 1,  0,   0));
        // Burst ror x3; live mode/shift_en changes during burst ignored
        tbl.push_back(mk(0,   1,  4'b1101, 0,  2'b00, 0,  0,    3'd0,   4'b1101, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b11, 0,  1,    3'd3,   4'b1101, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 0,  0,    3'd0,   4'b1110, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b01, 0,  1,    3'd1,   4'b0111, 0,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1011, 1,  0,   1));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1011, 1,  0,   0));
        // Burst lsr x2 filling with 1
        tbl.push_back(mk(0,   1,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b0000, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b01, 1,  1,    3'd2,   4'b0000, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 1,  0,    3'd0,   4'b1000, 0,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 1,  0,    3'd0,   4'b1100, 0,  0,   1));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1100, 0,  0,   0));
        // Zero-length burst: done only
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  1,    3'd0,   4'b1100, 0,  0,   1));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1100, 0,  0,   0));
        // Single steps rol, lsr, ror
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b10, 0,  0,    3'd0,   4'b1001, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b01, 0,  0,    3'd0,   4'b0100, 1,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b11, 0,  0,    3'd0,   4'b0010, 0,  0,   0));
        // Priority: load beats shift_en; start beats shift_en
        tbl.push_back(mk(0,   1,  4'b0011, 1,  2'b00, 1,  0,    3'd0,   4'b0011, 0,  0,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 1,  2'b00, 1,  1,    3'd1,   4'b0011, 0,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 1,  0,    3'd0,   4'b0111, 0,  0,   1));
        // count > WIDTH: rol x5 wraps
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b10, 0,  1,    3'd5,   4'b0111, 0,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1110, 0,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1101, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1011, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b0111, 1,  1,   0));
        tbl.push_back(mk(0,   0,  4'b0000, 0,  2'b00, 0,  0,    3'd0,   4'b1110, 0,  0,   1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Load aborts a rol burst on its second busy cycle: no done, serial_out held.
        apply(mk(0, 1, 4'b1101, 0, 2'b00, 0, 0, 3'd0, 4'b1101, 0, 0, 0), "abort.load");
        apply(mk(0, 0, 4'b0000, 0, 2'b10, 0, 1, 3'd4, 4'b1101, 0, 1, 0), "abort.start");
        apply(mk(0, 0, 4'b0000, 0, 2'b00, 0, 0, 3'd0, 4'b1011, 1, 1, 0), "abort.step1");
        apply(mk(0, 1, 4'b0110, 0, 2'b00, 0, 0, 3'd0, 4'b0110, 1, 0, 0), "abort.kill");
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 0, 4'b0000, 0, 2'b00, 0, 0, 3'd0, 4'b0110, 1, 0, 0), $sformatf("abort.idle%0d", i));
        end

        // Reset mid-burst after one lsl step: everything clears, no done.
        apply(mk(0, 1, 4'b1001, 0, 2'b00, 0, 0, 3'd0, 4'b1001, 1, 0, 0), "rstb.load");
        apply(mk(0, 0, 4'b0000, 0, 2'b00, 0, 1, 3'd4, 4'b1001, 1, 1, 0), "rstb.start");
        apply(mk(0, 0, 4'b0000, 0, 2'b00, 0, 0, 3'd0, 4'b0010, 1, 1, 0), "rstb.step1");
        apply(mk(1, 0, 4'b0000, 0, 2'b00, 0, 0, 3'd0, 4'b0000, 0, 0, 0), "rstb.rst");
        for (int i = 0; i < 3; i++) begin
            apply(mk(0, 0, 4'b0000, 0, 2'b00, 0, 0, 3'd0, 4'b0000, 0, 0, 0), $sformatf("rstb.idle%0d", i));
        end

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
